// File: rtl/axis_video_pkg.sv
`default_nettype none
// axis_video_pkg: shared state encoding, default widths and sizing helpers
// for the row-aligned AXI4-Stream video buffers.  Rev 1.0
package axis_video_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int AXIS_PKT_W  = 8;
  localparam int AXIS_ROW_W  = 20;
  localparam int AXIS_N_ROWS = 2;
  localparam int AXIS_BUF_W  = AXIS_ROW_W * AXIS_N_ROWS;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_row_beat_slice.sv
`default_nettype none
// axis_row_beat_slice: selects one beat of one row from a wide word, with
// bits past the end of the row forced to zero.  Rev 1.0
module axis_row_beat_slice
  import axis_video_pkg::*;
#(
  parameter  int AXI_PACKET_SIZE = AXIS_PKT_W,
  parameter  int ROW_SIZE        = AXIS_ROW_W,
  parameter  int N_ROWS          = AXIS_N_ROWS,
  parameter  int BUFFER_SIZE     = AXIS_BUF_W,
  localparam int BEATS_PER_ROW   = ceil_div(ROW_SIZE, AXI_PACKET_SIZE),
  localparam int ROW_IW          = idx_width(N_ROWS),
  localparam int BEAT_IW         = idx_width(BEATS_PER_ROW)
) (
  input  logic [BUFFER_SIZE-1:0]     shadow_i,
  input  logic [ROW_IW-1:0]          row_idx_i,
  input  logic [BEAT_IW-1:0]         beat_idx_i,
  output logic [AXI_PACKET_SIZE-1:0] tdata_o
);

  localparam int PAD_W = BEATS_PER_ROW * AXI_PACKET_SIZE;

  logic [ROW_SIZE-1:0]        rows   [N_ROWS];
  logic [AXI_PACKET_SIZE-1:0] beats  [BEATS_PER_ROW];
  logic [PAD_W-1:0]           padded;

  for (genvar r = 0; r < N_ROWS; r++) begin : g_rows
    assign rows[r] = shadow_i[r*ROW_SIZE +: ROW_SIZE];
  end

  // The receiver ORs padding into the next row, so it must be zero.
  always_comb begin
    padded                 = '0;
    padded[ROW_SIZE-1:0]   = rows[row_idx_i];
  end

  for (genvar b = 0; b < BEATS_PER_ROW; b++) begin : g_beats
    assign beats[b] = padded[b*AXI_PACKET_SIZE +: AXI_PACKET_SIZE];
  end

  assign tdata_o = beats[beat_idx_i];

endmodule
`default_nettype wire

// File: rtl/axi4stream_output_buffer.sv
`default_nettype none
// axi4stream_output_buffer: serializes a wide word into one row-aligned AXI4-Stream
// packet. Define AXIS_OUT_TUSER_SOF_EN for a tuser start-of-frame output.  Rev 1.0
module axi4stream_output_buffer
  import axis_video_pkg::*;
#(
  parameter  int AXI_PACKET_SIZE = AXIS_PKT_W,
  parameter  int BUFFER_SIZE     = AXIS_BUF_W,
  parameter  int ROW_SIZE        = AXIS_ROW_W,
  parameter  int N_ROWS          = AXIS_N_ROWS,
  localparam int BEATS_PER_ROW   = ceil_div(ROW_SIZE, AXI_PACKET_SIZE),
  localparam int ROW_IW          = idx_width(N_ROWS),
  localparam int BEAT_IW         = idx_width(BEATS_PER_ROW)
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [BUFFER_SIZE-1:0]     buffer,
  input  logic                       valid,
  output logic                       ready,
  output logic [AXI_PACKET_SIZE-1:0] tdata,
  output logic                       tvalid,
  output logic                       tlast,
  input  logic                       tready
`ifdef AXIS_OUT_TUSER_SOF_EN
  ,
  output logic                       tuser
`endif
);

  if (BUFFER_SIZE != ROW_SIZE * N_ROWS || AXI_PACKET_SIZE < 1) begin : g_param_check
    $error("axi4stream_output_buffer: BUFFER_SIZE must equal ROW_SIZE*N_ROWS and AXI_PACKET_SIZE >= 1");
  end

  localparam logic [ROW_IW-1:0]  ROW_LAST  = ROW_IW'(N_ROWS - 1);
  localparam logic [BEAT_IW-1:0] BEAT_LAST = BEAT_IW'(BEATS_PER_ROW - 1);

  state_e                   state_q;
  logic [ROW_IW-1:0]        row_idx_q;
  logic [BEAT_IW-1:0]       beat_idx_q;
  logic [BUFFER_SIZE-1:0]   shadow_q;
  logic [AXI_PACKET_SIZE-1:0] slice_data;
  logic                     sending;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      row_idx_q  <= '0;
      beat_idx_q <= '0;
      shadow_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid) begin
            shadow_q   <= buffer;
            row_idx_q  <= '0;
            beat_idx_q <= '0;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (tready) begin
            if (beat_idx_q == BEAT_LAST) begin
              beat_idx_q <= '0;
              if (row_idx_q == ROW_LAST) begin
                row_idx_q <= '0;
                state_q   <= IDLE;
              end else begin
                row_idx_q <= row_idx_q + 1'b1;
              end
            end else begin
              beat_idx_q <= beat_idx_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  axis_row_beat_slice #(
    .AXI_PACKET_SIZE (AXI_PACKET_SIZE),
    .ROW_SIZE        (ROW_SIZE),
    .N_ROWS          (N_ROWS),
    .BUFFER_SIZE     (BUFFER_SIZE)
  ) u_slice (
    .shadow_i   (shadow_q),
    .row_idx_i  (row_idx_q),
    .beat_idx_i (beat_idx_q),
    .tdata_o    (slice_data)
  );

  // All outputs decode registered state only; nothing flows from valid/tready.
  assign sending = (state_q == SEND);
  assign ready   = !sending;
  assign tvalid  = sending;
  assign tdata   = sending ? slice_data : '0;
  assign tlast   = sending && (row_idx_q == ROW_LAST) && (beat_idx_q == BEAT_LAST);

`ifdef AXIS_OUT_TUSER_SOF_EN
  assign tuser   = sending && (row_idx_q == '0) && (beat_idx_q == '0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi4stream_output_buffer.sv
`default_nettype none
// tb_axi4stream_output_buffer: randomized and directed stimulus against a
// beat-queue reference model of the packet serializer.
module tb_axi4stream_output_buffer;

  localparam int W    = 8;
  localparam int ROWS = 2;
  localparam int RSZ  = 20;
  localparam int BW   = 40;
  localparam int BPR  = (RSZ + W - 1) / W;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [BW-1:0] buffer;
  logic          valid;
  logic          ready;
  logic [W-1:0]  tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready;
  logic          tuser_obs;

  always #5 aclk = ~aclk;

  axi4stream_output_buffer #(
    .AXI_PACKET_SIZE (W),
    .BUFFER_SIZE     (BW),
    .ROW_SIZE        (RSZ),
    .N_ROWS          (ROWS)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .buffer  (buffer),
    .valid   (valid),
    .ready   (ready),
    .tdata   (tdata),
    .tvalid  (tvalid),
    .tlast   (tlast),
    .tready  (tready)
`ifdef AXIS_OUT_TUSER_SOF_EN
    ,
    .tuser   (tuser_obs)
`endif
  );

`ifndef AXIS_OUT_TUSER_SOF_EN
  assign tuser_obs = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
    logic         first;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference: every row is cut into BPR beats independently; bits past the row end read as 0.
  task automatic push_packet(input logic [BW-1:0] word);
    for (int r = 0; r < ROWS; r++) begin
      for (int b = 0; b < BPR; b++) begin
        beat_t          bt;
        logic [BW-1:0]  sh;
        bt.data  = '0;
        for (int i = 0; i < W; i++) begin
          int pos = b * W + i;
          if (pos < RSZ) begin
            sh = word >> (r * RSZ + pos);
            bt.data[i] = sh[0];
          end
        end
        bt.last  = (r == ROWS - 1) && (b == BPR - 1);
        bt.first = (r == 0) && (b == 0);
        exp_q.push_back(bt);
      end
    end
  endtask

  task automatic compare_outputs();
    if (exp_q.size() == 0) begin
      check("ready",  {63'd0, ready},  64'd1);
      check("tvalid", {63'd0, tvalid}, 64'd0);
      check("tlast",  {63'd0, tlast},  64'd0);
      check("tdata",  {56'd0, tdata},  64'd0);
      check("tuser",  {63'd0, tuser_obs}, 64'd0);
    end else begin
      check("ready",  {63'd0, ready},  64'd0);
      check("tvalid", {63'd0, tvalid}, 64'd1);
      check("tlast",  {63'd0, tlast},  {63'd0, exp_q[0].last});
      check("tdata",  {56'd0, tdata},  {56'd0, exp_q[0].data});
`ifdef AXIS_OUT_TUSER_SOF_EN
      check("tuser",  {63'd0, tuser_obs}, {63'd0, exp_q[0].first});
`else
      check("tuser",  {63'd0, tuser_obs}, 64'd0);
`endif
    end
  endtask

  // Drive one clock's worth of inputs, advance the model across the edge, then check.
  task automatic cycle(input logic v, input logic [BW-1:0] b, input logic tr, input logic rn);
    valid   = v;
    buffer  = b;
    tready  = tr;
    aresetn = rn;
    if (!rn) exp_q.delete();
    else if (exp_q.size() != 0) begin
      if (tr) void'(exp_q.pop_front());
    end else if (v) begin
      push_packet(b);
    end
    @(negedge aclk);
    cyc++;
    compare_outputs();
  endtask

  initial begin
    valid = 0; buffer = '0; tready = 0; aresetn = 0;

    cycle(0, '0, 0, 0);
    cycle(1, 40'h12345_ABCDE, 1, 0);

    // Basic packet, full throughput.
    cycle(1, 40'h12345_ABCDE, 1, 1);
    for (int i = 0; i < 7; i++) cycle(0, '0, 1, 1);

    // Backpressure pattern 1,0,0,1,...
    cycle(1, 40'h12345_ABCDE, 1, 1);
    for (int i = 0; i < 20; i++) cycle(0, '0, (i % 3) == 0, 1);
    for (int i = 0; i < 4; i++)  cycle(0, '0, 1, 1);

    // Padding of all-ones rows.
    cycle(1, 40'hFFFFF_FFFFF, 1, 1);
    for (int i = 0; i < 7; i++) cycle(0, '0, 1, 1);

    // Busy: valid with a different word mid-packet is ignored.
    cycle(1, 40'hA5A5A_5A5A5, 1, 1);
    for (int i = 0; i < 7; i++) cycle(1, '0, 1, 1);
    cycle(0, '0, 1, 1);

    // Reset in the middle of a packet, then a fresh load.
    cycle(1, 40'h13579_2468A, 1, 1);
    cycle(0, '0, 1, 1);
    cycle(0, '0, 1, 1);
    cycle(0, '0, 1, 0);
    cycle(1, 40'h0F0F0_C3C3C, 1, 1);
    for (int i = 0; i < 7; i++) cycle(0, '0, 1, 1);

    // Two consecutive packets with the first beat stalled.
    for (int p = 0; p < 2; p++) begin
      cycle(1, 40'h11111_22222 * (p + 1), 0, 1);
      cycle(0, '0, 0, 1);
      cycle(0, '0, 0, 1);
      for (int i = 0; i < 7; i++) cycle(0, '0, 1, 1);
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic [BW-1:0] w;
      w = {$urandom(), $urandom()} >> 24;
      cycle($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) != 0,
            $urandom_range(0, 60) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
